// File: rtl/nn_loader_pkg.sv
// Shared types and elaboration-time topology helpers for the NN stream loader.
// Neuron counts are packed 16 bits per layer, layer 0 in the LSBs.
package nn_loader_pkg;

  typedef enum logic [1:0] {StIdle, StLoadW, StLoadX, StDrain} state_e;

  localparam int unsigned NeuronBits   = 16;
  localparam int unsigned MaxLayersCap = 16;

  typedef logic [MaxLayersCap*NeuronBits-1:0] neurons_vec_t;

  // Words for layer l: one bias plus one weight per input, for every neuron.
  function automatic int unsigned layer_words(input int unsigned l, input int unsigned n_inputs,
                                              input neurons_vec_t vec);
    int unsigned n_in;
    int unsigned n_out;
    n_out = 32'(vec[l*NeuronBits +: NeuronBits]);
    if (l == 0) begin
      n_in = n_inputs;
    end else begin
      n_in = 32'(vec[(l-1)*NeuronBits +: NeuronBits]);
    end
    return (n_in + 1) * n_out;
  endfunction

  function automatic int unsigned total_words(input int unsigned num_layers,
                                              input int unsigned n_inputs,
                                              input neurons_vec_t vec);
    int unsigned sum;
    sum = 0;
    for (int unsigned l = 0; l < num_layers; l++) begin
      sum += layer_words(l, n_inputs, vec);
    end
    return sum;
  endfunction

endpackage

// File: rtl/nn_layer_addr_counter.sv
// Layer/word address counter for weight packets: wraps the address at each layer's
// last word and flags the final word of the whole weight set.
module nn_layer_addr_counter
  import nn_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 16,
  parameter int unsigned MAX_LAYERS       = 4,
  parameter int unsigned NUMBER_LAYER     = 2,
  parameter int unsigned NUMBER_OF_INPUTS = 49,
  parameter logic [MAX_LAYERS*NeuronBits-1:0] NEURONS_VEC = {16'd0, 16'd0, 16'd3, 16'd10},
  localparam int unsigned LayerW = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  advance,
  output logic [LayerW-1:0]     layer,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  layer_last,
  output logic                  total_last
);

  localparam neurons_vec_t VecExt = (MaxLayersCap*NeuronBits)'(NEURONS_VEC);
  localparam int unsigned TotalWords = total_words(NUMBER_LAYER, NUMBER_OF_INPUTS, VecExt);

  logic [ADDR_WIDTH-1:0] last_addr [MAX_LAYERS];

  for (genvar g = 0; g < MAX_LAYERS; g++) begin : g_last
    assign last_addr[g] = ADDR_WIDTH'(layer_words(g, NUMBER_OF_INPUTS, VecExt) - 1);
  end

  logic [LayerW-1:0]     layer_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           count_q;

  assign layer      = layer_q;
  assign addr       = addr_q;
  assign layer_last = (addr_q == last_addr[layer_q]);
  assign total_last = (count_q == 32'(TotalWords - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      layer_q <= '0;
      addr_q  <= '0;
      count_q <= '0;
    end else if (advance) begin
      count_q <= count_q + 32'd1;
      if (layer_last) begin
        addr_q  <= '0;
        layer_q <= layer_q + 1'b1;
      end else begin
        addr_q <= addr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nn_stream_loader.sv
// AXI-Stream ingress for the NN coprocessor: routes weight packets into per-layer memory
// and input frames into the input buffer, checking packet length against the topology.
module nn_stream_loader
  import nn_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ADDR_WIDTH       = 16,
  parameter int unsigned MAX_LAYERS       = 4,
  parameter int unsigned NUMBER_LAYER     = 2,
  parameter logic [MAX_LAYERS*NeuronBits-1:0] NEURONS_VEC = {16'd0, 16'd0, 16'd3, 16'd10},
  parameter int unsigned NUMBER_OF_INPUTS = 49,
  localparam int unsigned LayerW = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1,
  localparam int unsigned XAddrW = (NUMBER_OF_INPUTS > 1) ? $clog2(NUMBER_OF_INPUTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_tdata,
  input  logic                  rx_tvalid,
  input  logic                  rx_tlast,
  output logic                  rx_tready,
  input  logic                  start_load_w,
  output logic                  w_wr_en,
  output logic [LayerW-1:0]     w_wr_layer,
  output logic [ADDR_WIDTH-1:0] w_wr_addr,
  output logic [DATA_WIDTH-1:0] w_wr_data,
  output logic                  x_wr_en,
  output logic [XAddrW-1:0]     x_wr_addr,
  output logic [DATA_WIDTH-1:0] x_wr_data,
  output logic                  x_frame_valid,
  input  logic                  x_frame_ack,
  output logic                  weights_loaded,
  output logic                  len_err
);

  state_e                state_q;
  logic                  w_wr_en_q, x_wr_en_q, x_frame_valid_q, weights_loaded_q, len_err_q;
  logic [LayerW-1:0]     w_wr_layer_q;
  logic [ADDR_WIDTH-1:0] w_wr_addr_q;
  logic [DATA_WIDTH-1:0] w_wr_data_q, x_wr_data_q;
  logic [XAddrW-1:0]     x_wr_addr_q, x_idx_q;

  logic                  accept, x_last, cnt_clear, cnt_advance, total_last;
  logic [LayerW-1:0]     cnt_layer;
  logic [ADDR_WIDTH-1:0] cnt_addr;

  assign rx_tready   = (state_q != StIdle);
  assign accept      = rx_tvalid & rx_tready;
  assign x_last      = (x_idx_q == XAddrW'(NUMBER_OF_INPUTS - 1));
  assign cnt_clear   = (state_q == StIdle) & start_load_w;
  assign cnt_advance = (state_q == StLoadW) & accept;

  nn_layer_addr_counter #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .MAX_LAYERS      (MAX_LAYERS),
    .NUMBER_LAYER    (NUMBER_LAYER),
    .NUMBER_OF_INPUTS(NUMBER_OF_INPUTS),
    .NEURONS_VEC     (NEURONS_VEC)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt_clear),
    .advance   (cnt_advance),
    .layer     (cnt_layer),
    .addr      (cnt_addr),
    .layer_last(),
    .total_last(total_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      w_wr_en_q        <= 1'b0;
      w_wr_layer_q     <= '0;
      w_wr_addr_q      <= '0;
      w_wr_data_q      <= '0;
      x_wr_en_q        <= 1'b0;
      x_wr_addr_q      <= '0;
      x_wr_data_q      <= '0;
      x_idx_q          <= '0;
      x_frame_valid_q  <= 1'b0;
      weights_loaded_q <= 1'b0;
      len_err_q        <= 1'b0;
    end else begin
      w_wr_en_q <= 1'b0;
      x_wr_en_q <= 1'b0;
      if (x_frame_valid_q && x_frame_ack) begin
        x_frame_valid_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (start_load_w) begin
            weights_loaded_q <= 1'b0;
            len_err_q        <= 1'b0;
            state_q          <= StLoadW;
          end else if (weights_loaded_q && !x_frame_valid_q && rx_tvalid) begin
            x_idx_q <= '0;
            state_q <= StLoadX;
          end
        end
        StLoadW: begin
          if (accept) begin
            w_wr_en_q    <= 1'b1;
            w_wr_layer_q <= cnt_layer;
            w_wr_addr_q  <= cnt_addr;
            w_wr_data_q  <= rx_tdata;
            if (total_last) begin
              if (rx_tlast) begin
                weights_loaded_q <= 1'b1;
                state_q          <= StIdle;
              end else begin
                len_err_q <= 1'b1;
                state_q   <= StDrain;
              end
            end else if (rx_tlast) begin
              // Short packet: writes already issued stay, weight set stays invalid.
              len_err_q <= 1'b1;
              state_q   <= StIdle;
            end
          end
        end
        StLoadX: begin
          if (accept) begin
            x_wr_en_q   <= 1'b1;
            x_wr_addr_q <= x_idx_q;
            x_wr_data_q <= rx_tdata;
            x_idx_q     <= x_idx_q + 1'b1;
            if (x_last) begin
              if (rx_tlast) begin
                x_frame_valid_q <= 1'b1;
                state_q         <= StIdle;
              end else begin
                len_err_q <= 1'b1;
                state_q   <= StDrain;
              end
            end else if (rx_tlast) begin
              len_err_q <= 1'b1;
              state_q   <= StIdle;
            end
          end
        end
        StDrain: begin
          if (accept && rx_tlast) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign w_wr_en        = w_wr_en_q;
  assign w_wr_layer     = w_wr_layer_q;
  assign w_wr_addr      = w_wr_addr_q;
  assign w_wr_data      = w_wr_data_q;
  assign x_wr_en        = x_wr_en_q;
  assign x_wr_addr      = x_wr_addr_q;
  assign x_wr_data      = x_wr_data_q;
  assign x_frame_valid  = x_frame_valid_q;
  assign weights_loaded = weights_loaded_q;
  assign len_err        = len_err_q;

endmodule

// File: tb/tb_nn_stream_loader.sv
// Directed bench for nn_stream_loader: default two-layer topology plus a three-layer
// instance, covering length errors, frame backpressure, stalls and mid-packet reset.
module tb_nn_stream_loader;

  typedef struct {
    int          layer;
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst, rx_tvalid, rx_tlast, start_load_w, x_frame_ack, sel;
  logic [31:0] rx_tdata;

  logic        rdy1, w_en1, x_en1, xfv1, wl1, le1;
  logic [1:0]  w_layer1;
  logic [15:0] w_addr1;
  logic [31:0] w_data1, x_data1;
  logic [5:0]  x_addr1;

  logic        rdy2, w_en2, x_en2, xfv2, wl2, le2;
  logic [1:0]  w_layer2;
  logic [15:0] w_addr2;
  logic [31:0] w_data2, x_data2;
  logic [2:0]  x_addr2;

  logic rdy;
  assign rdy = sel ? rdy2 : rdy1;

  int n_cmp = 0;
  int n_err = 0;
  wr_t wq1[$], xq1[$], wq2[$];

  always #5 clk = ~clk;

  nn_stream_loader u_dut1 (
    .clk(clk), .rst(rst), .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid & ~sel),
    .rx_tlast(rx_tlast), .rx_tready(rdy1), .start_load_w(start_load_w & ~sel),
    .w_wr_en(w_en1), .w_wr_layer(w_layer1), .w_wr_addr(w_addr1), .w_wr_data(w_data1),
    .x_wr_en(x_en1), .x_wr_addr(x_addr1), .x_wr_data(x_data1), .x_frame_valid(xfv1),
    .x_frame_ack(x_frame_ack & ~sel), .weights_loaded(wl1), .len_err(le1)
  );

  nn_stream_loader #(
    .NUMBER_LAYER(3), .NEURONS_VEC({16'd0, 16'd4, 16'd3, 16'd10}), .NUMBER_OF_INPUTS(8)
  ) u_dut2 (
    .clk(clk), .rst(rst), .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid & sel),
    .rx_tlast(rx_tlast), .rx_tready(rdy2), .start_load_w(start_load_w & sel),
    .w_wr_en(w_en2), .w_wr_layer(w_layer2), .w_wr_addr(w_addr2), .w_wr_data(w_data2),
    .x_wr_en(x_en2), .x_wr_addr(x_addr2), .x_wr_data(x_data2), .x_frame_valid(xfv2),
    .x_frame_ack(x_frame_ack & sel), .weights_loaded(wl2), .len_err(le2)
  );

  always @(negedge clk) begin
    if (w_en1) wq1.push_back('{int'(w_layer1), int'(w_addr1), w_data1});
    if (x_en1) xq1.push_back('{0, int'(x_addr1), x_data1});
    if (w_en2) wq2.push_back('{int'(w_layer2), int'(w_addr2), w_data2});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_start();
    start_load_w = 1'b1;
    tick();
    start_load_w = 1'b0;
  endtask

  task automatic idle();
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
  endtask

  // Present one beat and return just after the edge that accepts it.
  task automatic beat(input logic [31:0] d, input logic last);
    int n;
    n = 0;
    rx_tvalid = 1'b1;
    rx_tdata  = d;
    rx_tlast  = last;
    @(negedge clk);
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) begin
      n_cmp++;
      n_err++;
      $error("FAIL accept_timeout: observed ready=0 after %0d cycles, expected ready=1", n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) beat(base + i, (i == n - 1));
    idle();
  endtask

  function automatic int bad_w(input wr_t q[$], input int sizes[3], input logic [31:0] base);
    int l, a, bad;
    l = 0; a = 0; bad = 0;
    foreach (q[i]) begin
      if (q[i].layer != l || q[i].addr != a || q[i].data != base + i) bad++;
      a++;
      if (l < 3 && a == sizes[l]) begin
        a = 0;
        l++;
      end
    end
    return bad;
  endfunction

  function automatic int bad_x(input wr_t q[$], input logic [31:0] base);
    int bad;
    bad = 0;
    foreach (q[i]) if (q[i].addr != i || q[i].data != base + i) bad++;
    return bad;
  endfunction

  initial begin
    rst = 1'b1; sel = 1'b0; start_load_w = 1'b0; x_frame_ack = 1'b0;
    rx_tdata = '0; idle();
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", rdy1, 0);
    check("rst_w_en", w_en1, 0);
    check("rst_x_en", x_en1, 0);
    check("rst_xfv", xfv1, 0);
    check("rst_wl", wl1, 0);
    check("rst_len_err", le1, 0);
    check("rst_x_addr2", x_addr2, 0);
    check("rst_x_data2", x_data2, 0);
    check("rst_ready2", rdy2, 0);

    // Full weight load: 500 words for layer 0, 33 for layer 1.
    tick();
    wq1.delete();
    pulse_start();
    send_pkt(533, 32'hA000_0000);
    settle();
    check("w_count", wq1.size(), 533);
    check("w_seq_bad", bad_w(wq1, '{500, 33, 0}, 32'hA000_0000), 0);
    check("w_l0_end", {wq1[499].layer, wq1[499].addr}, {32'd0, 32'd499});
    check("w_l1_start", {wq1[500].layer, wq1[500].addr}, {32'd1, 32'd0});
    check("w_l1_end", {wq1[532].layer, wq1[532].addr}, {32'd1, 32'd32});
    check("w_loaded", wl1, 1);
    check("w_len_err", le1, 0);
    check("w_idle_ready", rdy1, 0);

    // Input frame, then a second one held off until ack.
    tick();
    xq1.delete();
    send_pkt(49, 32'h5000);
    settle();
    check("x_count", xq1.size(), 49);
    check("x_seq_bad", bad_x(xq1, 32'h5000), 0);
    check("x_frame_valid", xfv1, 1);
    xq1.delete();
    rx_tvalid = 1'b1; rx_tdata = 32'h6000; rx_tlast = 1'b0;
    repeat (5) @(negedge clk);
    check("bp_ready", rdy1, 0);
    check("bp_xfv_held", xfv1, 1);
    check("bp_no_writes", xq1.size(), 0);
    @(posedge clk); #1;
    x_frame_ack = 1'b1;
    tick();
    x_frame_ack = 1'b0;
    @(negedge clk);
    check("ack_clear", xfv1, 0);
    send_pkt(49, 32'h6000);
    settle();
    check("x2_count", xq1.size(), 49);
    check("x2_seq_bad", bad_x(xq1, 32'h6000), 0);
    check("x2_frame_valid", xfv1, 1);
    @(posedge clk); #1;
    x_frame_ack = 1'b1;
    tick();
    x_frame_ack = 1'b0;
    @(negedge clk);
    check("x2_ack_clear", xfv1, 0);

    // Short weight packet: tlast on beat 100.
    tick();
    wq1.delete();
    pulse_start();
    for (int i = 0; i < 100; i++) beat(32'hD000_0000 + i, (i == 99));
    idle();
    settle();
    check("short_w_count", wq1.size(), 100);
    check("short_len_err", le1, 1);
    check("short_wl", wl1, 0);
    check("short_idle", rdy1, 0);
    rx_tvalid = 1'b1; rx_tdata = 32'h1; rx_tlast = 1'b0;
    repeat (4) @(negedge clk);
    check("no_frame_wo_weights", rdy1, 0);
    tick();
    idle();

    // Reload, then an over-long 52-beat frame.
    wq1.delete();
    pulse_start();
    send_pkt(533, 32'hB000_0000);
    settle();
    check("reload_wl", wl1, 1);
    check("reload_len_err_clr", le1, 0);
    tick();
    xq1.delete();
    send_pkt(52, 32'h7000);
    settle();
    check("long_x_count", xq1.size(), 49);
    check("long_x_seq_bad", bad_x(xq1, 32'h7000), 0);
    check("long_len_err", le1, 1);
    check("long_xfv", xfv1, 0);
    check("long_idle", rdy1, 0);
    check("long_wl_kept", wl1, 1);

    // Stalled weight reload, reset after beat 200.
    tick();
    wq1.delete();
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      beat(32'hE000_0000 + i, 1'b0);
      if ((i + 1) % 7 == 0 && i != 199) begin
        idle();
        repeat (3) tick();
      end
    end
    rst = 1'b1;
    idle();
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check("stall_count", wq1.size(), 200);
    check("stall_seq_bad", bad_w(wq1, '{500, 33, 0}, 32'hE000_0000), 0);
    check("rst2_w_en", w_en1, 0);
    check("rst2_w_addr", w_addr1, 0);
    check("rst2_wl", wl1, 0);
    check("rst2_ready", rdy1, 0);
    check("rst2_len_err", le1, 0);
    check("rst2_xfv", xfv1, 0);

    // Three-layer instance: 90 / 33 / 16 words.
    tick();
    sel = 1'b1;
    wq2.delete();
    pulse_start();
    send_pkt(139, 32'hC000_0000);
    settle();
    check("l3_count", wq2.size(), 139);
    check("l3_seq_bad", bad_w(wq2, '{90, 33, 16}, 32'hC000_0000), 0);
    check("l3_l0_end", {wq2[89].layer, wq2[89].addr}, {32'd0, 32'd89});
    check("l3_l1_start", {wq2[90].layer, wq2[90].addr}, {32'd1, 32'd0});
    check("l3_l1_end", {wq2[122].layer, wq2[122].addr}, {32'd1, 32'd32});
    check("l3_l2_start", {wq2[123].layer, wq2[123].addr}, {32'd2, 32'd0});
    check("l3_l2_end", {wq2[138].layer, wq2[138].addr}, {32'd2, 32'd15});
    check("l3_wl", wl2, 1);
    check("l3_len_err", le2, 0);
    check("l3_no_x", {x_en2, xfv2}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nn_stream_loader.md
Name: nn_stream_loader

Overview:
- AXI-Stream ingress front-end for the NN coprocessor, between rx_* and the core weight/input memories.
- Parametrised successor to the fixed two-layer loader: supports up to MAX_LAYERS layers with a per-layer neuron count.
- Two modes, each one packet: weight load (bias + weights, routed per layer) and input-frame load.
- Checks packet length against the configured topology; holds each completed input frame until the core acknowledges it.

Parameters:
- DATA_WIDTH, 32, stream word width.
- ADDR_WIDTH, 16, weight memory word address width.
- MAX_LAYERS, 4, maximum number of layers supported.
- NUMBER_LAYER, 2, active layer count, 1..MAX_LAYERS.
- NEURONS_VEC, {16'd0,16'd0,16'd3,16'd10}, packed neuron count per layer, 16 bits each, layer 0 in LSBs.
- NUMBER_OF_INPUTS, 49, input vector length.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rx_tdata  in  DATA_WIDTH  stream data
- rx_tvalid  in  1  stream valid
- rx_tlast  in  1  end of packet
- rx_tready  out  1  stream ready
- start_load_w  in  1  pulse: next packet is a weight load
- w_wr_en  out  1  weight write strobe
- w_wr_layer  out  $clog2(MAX_LAYERS)  target layer
- w_wr_addr  out  ADDR_WIDTH  word address within layer
- w_wr_data  out  DATA_WIDTH  weight word
- x_wr_en  out  1  input buffer write strobe
- x_wr_addr  out  $clog2(NUMBER_OF_INPUTS)  input index
- x_wr_data  out  DATA_WIDTH  input word
- x_frame_valid  out  1  complete frame held in buffer
- x_frame_ack  in  1  core consumed frame
- weights_loaded  out  1  valid weight set present (nn_ready)
- len_err  out  1  sticky packet-length error

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0. A reset mid-packet abandons the packet and clears weights_loaded.
- Layer sizes:
  - W(l) = (in(l)+1)*N(l), with in(0) = NUMBER_OF_INPUTS and in(l) = N(l-1).
  - Word order per neuron: bias first, then weights.
  - W_TOTAL is the sum over active layers; all sizes are elaboration-time constants.
- Beat acceptance: a beat is accepted when rx_tvalid & rx_tready. Write strobes are registered and appear 1 cycle after acceptance, with the captured data and address.
- IDLE:
  - rx_tready = 0.
  - start_load_w -> LOAD_W: clears weights_loaded and len_err, resets the layer/address counters.
  - Otherwise, if weights_loaded & !x_frame_valid & rx_tvalid -> LOAD_X. rx_tready rises the next cycle.
  - If start_load_w and rx_tvalid coincide, start_load_w wins.
- LOAD_W:
  - rx_tready = 1. Each accepted beat writes (layer, addr), then addr++.
  - When addr reaches W(layer)-1: addr <= 0, layer++.
  - On the beat with global count W_TOTAL-1:
    - with rx_tlast -> weights_loaded = 1, go to IDLE;
    - without rx_tlast -> len_err = 1, go to DRAIN.
  - rx_tlast on an earlier beat -> len_err = 1, weights_loaded stays 0, go to IDLE. Writes already issued are not rolled back.
- LOAD_X:
  - rx_tready = 1. Each accepted beat writes x_wr_addr, then the index increments.
  - Beat NUMBER_OF_INPUTS-1:
    - with tlast -> x_frame_valid = 1, go to IDLE;
    - without tlast -> len_err = 1, go to DRAIN, frame discarded.
  - Early tlast -> len_err = 1, frame discarded, go to IDLE.
- DRAIN: rx_tready = 1; discard beats until a beat with tlast is accepted, then go to IDLE. No writes.
- x_frame_valid: held until x_frame_ack, cleared the cycle after ack. An ack while x_frame_valid = 0 is ignored. No new frame is accepted while x_frame_valid = 1 (backpressure).
- start_load_w outside IDLE is ignored.
- len_err is sticky until the next start_load_w or rst.

Decomposition:
- Package nn_loader_pkg:
  - state enum {IDLE, LOAD_W, LOAD_X, DRAIN};
  - constant function layer_words(l) returning W(l);
  - constant function total_words() returning W_TOTAL.
- Sub-module nn_layer_addr_counter: layer/address counter with per-layer wrap, load-clear and last-word flags.

Test Plan:
- Default params; start_load_w, then 533 beats (500 + 33) with tlast on beat 533 -> w_wr_en 533 times; layer 0 addresses 0..499, layer 1 addresses 0..32; weights_loaded = 1; len_err = 0.
- After weights load, send a 49-beat frame with tlast -> x_wr_addr 0..48, x_frame_valid = 1. A second frame sees rx_tready = 0 until x_frame_ack; one cycle after ack, x_frame_valid = 0 and the frame is accepted.
- Weight packet with tlast on beat 100 -> len_err = 1, weights_loaded = 0, state IDLE; a following frame is not accepted (rx_tready = 0).
- 52-beat input frame, tlast on beat 52 -> 49 writes, beats 50..52 drained, len_err = 1, x_frame_valid = 0.
- rx_tvalid stalls of 3 cycles every 7 beats during weight load, and rst asserted at beat 200 of a reload -> addresses contiguous across stalls; after rst all outputs 0 and weights_loaded = 0.
- NUMBER_LAYER = 3, NEURONS_VEC = {0,4,3,10}, 8 inputs -> layer sizes 90/33/16, total 139; correct layer boundaries and weights_loaded = 1.
